// File: rtl/load_writeback_unit_if.sv
// Handshake and bus bundle for load_writeback_unit: execute input, data memory
// read channel and register file write port.
interface load_writeback_unit_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_wen;
   logic                  in_is_load;
   logic [2:0]            in_funct3;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rsp_data;
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;

   // Environment side: execute, memory and register file models
   modport master (
      output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_result,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  in_ready, mem_req_valid, mem_addr, rf_wen, rf_waddr, rf_wdata
   );

   // Writeback unit side
   modport slave (
      input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_result,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output in_ready, mem_req_valid, mem_addr, rf_wen, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/load_writeback_unit.sv
// Writeback stage feeding the register file write port. ALU results are
// written one cycle after accept; loads go IDLE->REQ->WAIT->WB and write the
// extracted, extended lane. Optional feature macro: MISALIGN_CHECK_EN adds
// misalign_err and rejects misaligned LH/LHU/LW in IDLE.
module load_writeback_unit #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   load_writeback_unit_if.slave bus
`ifdef MISALIGN_CHECK_EN
   ,
   output logic misalign_err
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_mem_req_valid;
   logic [DATA_WIDTH-1:0] r_mem_addr;
   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_waddr;
   logic [DATA_WIDTH-1:0] r_rf_wdata;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic                  r_wen;
   logic [2:0]            r_funct3;
   logic [1:0]            r_addr_lo;
   logic                  w_accept;

   // Select the addressed lane and extend it according to funct3
   function automatic logic [DATA_WIDTH-1:0] f_extract(
      input logic [2:0]            f3,
      input logic [1:0]            a,
      input logic [DATA_WIDTH-1:0] w
   );
      logic [DATA_WIDTH-1:0] sh_b;
      logic [DATA_WIDTH-1:0] sh_h;
      logic [7:0]            b;
      logic [15:0]           h;
      sh_b = w >> {a, 3'b000};
      sh_h = w >> {a[1], 4'b0000};
      b    = sh_b[7:0];
      h    = sh_h[15:0];
      case (f3)
         3'b000:  f_extract = {{(DATA_WIDTH-8){b[7]}}, b};
         3'b001:  f_extract = {{(DATA_WIDTH-16){h[15]}}, h};
         3'b100:  f_extract = {{(DATA_WIDTH-8){1'b0}}, b};
         3'b101:  f_extract = {{(DATA_WIDTH-16){1'b0}}, h};
         default: f_extract = w;
      endcase
   endfunction

   assign w_accept = bus.in_valid & r_in_ready;

`ifdef MISALIGN_CHECK_EN
   logic r_misalign_err;
   logic w_misalign;

   // Halfword needs addr[0]==0; word-class funct3 (x1x) needs addr[1:0]==0
   assign w_misalign = ((bus.in_funct3[1:0] == 2'b01) & bus.in_result[0]) |
                       (bus.in_funct3[1] & (|bus.in_result[1:0]));
   assign misalign_err = r_misalign_err;
`endif

   // Load sequencing FSM with registered handshake and regfile outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_in_ready      <= 1'b1;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_rf_wen        <= 1'b0;
         r_rf_waddr      <= '0;
         r_rf_wdata      <= '0;
         r_rd            <= '0;
         r_wen           <= 1'b0;
         r_funct3        <= '0;
         r_addr_lo       <= '0;
`ifdef MISALIGN_CHECK_EN
         r_misalign_err  <= 1'b0;
`endif
      end else begin
         r_rf_wen <= 1'b0;
`ifdef MISALIGN_CHECK_EN
         r_misalign_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (!bus.in_is_load) begin
                     r_rf_wen   <= bus.in_wen & (bus.in_rd != '0);
                     r_rf_waddr <= bus.in_rd;
                     r_rf_wdata <= bus.in_result;
                  end
`ifdef MISALIGN_CHECK_EN
                  else if (w_misalign) begin
                     r_misalign_err <= 1'b1;
                  end
`endif
                  else begin
                     r_rd            <= bus.in_rd;
                     r_wen           <= bus.in_wen;
                     r_funct3        <= bus.in_funct3;
                     r_addr_lo       <= bus.in_result[1:0];
                     r_mem_addr      <= {bus.in_result[DATA_WIDTH-1:2], 2'b00};
                     r_mem_req_valid <= 1'b1;
                     r_in_ready      <= 1'b0;
                     r_state         <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mem_rsp_valid) begin
                  r_rf_wen   <= r_wen & (r_rd != '0);
                  r_rf_waddr <= r_rd;
                  r_rf_wdata <= f_extract(r_funct3, r_addr_lo, bus.mem_rsp_data);
                  r_state    <= S_WB;
               end
            end
            S_WB: begin
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.mem_req_valid = r_mem_req_valid;
   assign bus.mem_addr      = r_mem_addr;
   assign bus.rf_wen        = r_rf_wen;
   assign bus.rf_waddr      = r_rf_waddr;
   assign bus.rf_wdata      = r_rf_wdata;
endmodule
